// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon game core.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Button index width; never narrower than one bit.
    function automatic int bw_f(input int num_buttons);
        return (num_buttons > 2) ? $clog2(num_buttons) : 1;
    endfunction

    // Level/score width: must hold the value DEPTH itself.
    function automatic int lw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Sequence memory address width.
    function automatic int aw_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_if.sv
// Player/rng side inputs and lamp/score outputs of the Simon core.
interface simon_if import simon_pkg::*; #(
    parameter int NUM_BUTTONS = 4,
    parameter int DEPTH       = 16
) ();
    localparam int BW = bw_f(NUM_BUTTONS);
    localparam int LW = lw_f(DEPTH);

    logic          START_GAME;
    logic [BW-1:0] IN;
    logic          IN_VALID;
    logic [BW-1:0] RAND;
    logic [BW-1:0] OUT;
    logic          OUT_ENA;
    logic [LW-1:0] LEVEL;
    logic [LW-1:0] HS_SCORE;
    logic          WIN;
    logic          LOSE;
    logic          HS;
    logic          BUSY;

    modport master (
        output START_GAME, IN, IN_VALID, RAND,
        input  OUT, OUT_ENA, LEVEL, HS_SCORE, WIN, LOSE, HS, BUSY
    );

    modport slave (
        input  START_GAME, IN, IN_VALID, RAND,
        output OUT, OUT_ENA, LEVEL, HS_SCORE, WIN, LOSE, HS, BUSY
    );

endinterface

// File: rtl/simon_phase_timer.sv
// Phase timer: TICK_DIV prescaler feeding a tick counter; done pulses on the last cycle of load_ticks ticks.
// Latency: restart takes effect next cycle, done is combinational from state; backpressure: none.
module simon_phase_timer #(
    parameter int TICK_DIV = 500000,
    parameter int TW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic [TW-1:0] load_ticks,
    output logic          done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (pre_q == PW'(TICK_DIV - 1));
    assign done = wrap && (cnt_q == load_ticks - TW'(1));

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (restart) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (wrap) begin
            pre_d = '0;
            cnt_d = cnt_q + TW'(1);
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simon_engine.sv
// Simon game core: grows a random sequence each round, plays it on OUT, then checks player presses.
// Latency: press result visible one cycle after IN_VALID; backpressure: none, IN_VALID outside WAIT_IN is dropped.
module simon_engine import simon_pkg::*; #(
    parameter int NUM_BUTTONS   = 4,
    parameter int DEPTH         = 16,
    parameter int TICK_DIV      = 500000,
    parameter int ON_TICKS      = 250,
    parameter int OFF_TICKS     = 100,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic    CLK,
    input  logic    RST,
    simon_if.slave  bus
);
    localparam int BW = bw_f(NUM_BUTTONS);
    localparam int LW = lw_f(DEPTH);
    localparam int AW = aw_f(DEPTH);
    localparam int TW = $clog2(max3(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS) + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] hs_score_q, hs_score_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic          hs_q, hs_d;
    logic [BW-1:0] out_q, out_d;
    logic          start_q;
    logic [BW-1:0] mem_q [DEPTH];

    logic          start_edge;
    logic          mem_we;
    logic          press_ok;
    logic [BW-1:0] rand_mod;
    logic [BW-1:0] cur_btn;
    logic [LW-1:0] last_idx;
    logic [LW-1:0] score;
    logic [TW-1:0] load_ticks;
    logic          tmr_done;
    logic          tmr_restart;

    assign start_edge = bus.START_GAME && !start_q;
    assign cur_btn    = mem_q[idx_q[AW-1:0]];
    assign last_idx   = level_q - LW'(1);

    // RAND is below 2**BW < 2*NUM_BUTTONS, so one conditional subtract is a full modulo.
    always_comb begin
        rand_mod = bus.RAND;
        if (int'(bus.RAND) >= NUM_BUTTONS) begin
            rand_mod = bus.RAND - BW'(NUM_BUTTONS);
        end
    end

    always_comb begin
        case (state_q)
            SHOW_ON:  load_ticks = TW'(ON_TICKS);
            SHOW_OFF: load_ticks = TW'(OFF_TICKS);
            default:  load_ticks = TW'(TIMEOUT_TICKS);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        hs_score_d = hs_score_q;
        win_d      = win_q;
        lose_d     = lose_q;
        hs_d       = hs_q;
        mem_we     = 1'b0;
        press_ok   = 1'b0;
        score      = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d = ADD;
                    level_d = '0;
                    idx_d   = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    hs_d    = 1'b0;
                end
            end
            ADD: begin
                mem_we  = 1'b1;
                level_d = level_q + LW'(1);
                idx_d   = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (tmr_done) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (tmr_done) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = WAIT_IN;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = SHOW_ON;
                    end
                end
            end
            WAIT_IN: begin
                // A press on the expiry cycle wins over the timeout.
                if (bus.IN_VALID) begin
                    if (bus.IN != cur_btn) begin
                        state_d = DONE;
                        lose_d  = 1'b1;
                    end else if (idx_q < last_idx) begin
                        idx_d    = idx_q + LW'(1);
                        press_ok = 1'b1;
                    end else if (level_q == LW'(DEPTH)) begin
                        state_d = DONE;
                        win_d   = 1'b1;
                    end else begin
                        state_d = ADD;
                    end
                end else if (tmr_done) begin
                    state_d = DONE;
                    lose_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != DONE && state_d == DONE) begin
            score = win_d ? level_q : last_idx;
            if (score > hs_score_q) begin
                hs_score_d = score;
                hs_d       = 1'b1;
            end
        end
    end

    assign out_d       = (state_q == SHOW_ON) ? cur_btn : out_q;
    assign tmr_restart = (state_d != state_q) || press_ok;

    simon_phase_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .restart    (tmr_restart),
        .load_ticks (load_ticks),
        .done       (tmr_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            level_q    <= '0;
            idx_q      <= '0;
            hs_score_q <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            hs_q       <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            hs_score_q <= hs_score_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            hs_q       <= hs_d;
            out_q      <= out_d;
        end
    end

    // START_GAME history tracks through reset so a level held across reset is not an edge.
    always_ff @(posedge CLK) begin
        start_q <= bus.START_GAME;
        if (mem_we) mem_q[level_q[AW-1:0]] <= rand_mod;
    end

    assign bus.OUT      = out_d;
    assign bus.OUT_ENA  = (state_q == SHOW_ON);
    assign bus.LEVEL    = level_q;
    assign bus.HS_SCORE = hs_score_q;
    assign bus.WIN      = win_q;
    assign bus.LOSE     = lose_q;
    assign bus.HS       = hs_q;
    assign bus.BUSY     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_simon_engine.sv
// Directed bench: 4-button and 3-button cores, DEPTH=3, TICK_DIV=2, ON=3, OFF=1, TIMEOUT=8 ticks.
module tb_simon_engine;

    logic CLK;
    logic rst4;
    logic rst3;
    int   checks;
    int   errors;

    simon_if #(.NUM_BUTTONS(4), .DEPTH(3)) if4 ();
    simon_if #(.NUM_BUTTONS(3), .DEPTH(3)) if3 ();

    simon_engine #(
        .NUM_BUTTONS(4), .DEPTH(3), .TICK_DIV(2),
        .ON_TICKS(3), .OFF_TICKS(1), .TIMEOUT_TICKS(8)
    ) dut4 (
        .CLK (CLK),
        .RST (rst4),
        .bus (if4)
    );

    simon_engine #(
        .NUM_BUTTONS(3), .DEPTH(3), .TICK_DIV(2),
        .ON_TICKS(3), .OFF_TICKS(1), .TIMEOUT_TICKS(8)
    ) dut3 (
        .CLK (CLK),
        .RST (rst3),
        .bus (if3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press on the 4-button (sel=0) or 3-button (sel=1) core; returns one cycle later.
    task automatic press(input bit sel, input int btn);
        if (sel) begin
            if3.IN       = btn[1:0];
            if3.IN_VALID = 1'b1;
        end else begin
            if4.IN       = btn[1:0];
            if4.IN_VALID = 1'b1;
        end
        step();
        if3.IN_VALID = 1'b0;
        if4.IN_VALID = 1'b0;
    endtask

    // Called on the first SHOW_ON cycle of the 4-button core; returns on the cycle after the dark gap.
    task automatic show4(input int exp_btn);
        int n;
        chk("show_out", if4.OUT, exp_btn);
        n = 0;
        while (if4.OUT_ENA === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("on_len", n, 6);
        chk("off_out_hold", if4.OUT, exp_btn);
        chk("off1_ena", if4.OUT_ENA, 0);
        step();
        chk("off2_ena", if4.OUT_ENA, 0);
        step();
    endtask

    task automatic start4();
        if4.START_GAME = 1'b1;
        step();
        chk("start_busy", if4.BUSY, 1);
        chk("start_level", if4.LEVEL, 0);
        chk("start_win", if4.WIN, 0);
        chk("start_lose", if4.LOSE, 0);
        chk("start_hs", if4.HS, 0);
        if4.START_GAME = 1'b0;
    endtask

    task automatic add4(input int rnd, input int exp_level);
        if4.RAND = rnd[1:0];
        step();
        chk("add_level", if4.LEVEL, exp_level);
        chk("add_ena", if4.OUT_ENA, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst4 = 1'b1;
        rst3 = 1'b1;
        if4.START_GAME = 1'b0; if4.IN = '0; if4.IN_VALID = 1'b0; if4.RAND = '0;
        if3.START_GAME = 1'b0; if3.IN = '0; if3.IN_VALID = 1'b0; if3.RAND = '0;
        steps(3);

        // Reset state, and a START edge under reset does nothing
        chk("rst_out", if4.OUT, 0);
        chk("rst_ena", if4.OUT_ENA, 0);
        chk("rst_level", if4.LEVEL, 0);
        chk("rst_hs_score", if4.HS_SCORE, 0);
        chk("rst_win", if4.WIN, 0);
        chk("rst_lose", if4.LOSE, 0);
        chk("rst_hs", if4.HS, 0);
        chk("rst_busy", if4.BUSY, 0);
        if4.START_GAME = 1'b1;
        steps(2);
        chk("rst_start_busy", if4.BUSY, 0);
        rst4 = 1'b0;
        rst3 = 1'b0;
        steps(2);
        chk("post_rst_busy", if4.BUSY, 0);
        chk("post_rst_level", if4.LEVEL, 0);
        if4.START_GAME = 1'b0;
        step();

        // Game 1: perfect game, RAND 2,0,3
        start4();
        add4(2, 1);
        show4(2);
        chk("wait_busy", if4.BUSY, 1);
        chk("wait_ena", if4.OUT_ENA, 0);
        press(0, 2);
        chk("r1_add_busy", if4.BUSY, 1);
        chk("r1_add_level", if4.LEVEL, 1);
        add4(0, 2);
        show4(2);
        show4(0);
        press(0, 2);
        chk("r2_mid_busy", if4.BUSY, 1);
        press(0, 0);
        add4(3, 3);
        show4(2);
        show4(0);
        show4(3);
        press(0, 2);
        press(0, 0);
        chk("r3_pre_win", if4.WIN, 0);
        press(0, 3);
        chk("g1_win", if4.WIN, 1);
        chk("g1_lose", if4.LOSE, 0);
        chk("g1_level", if4.LEVEL, 3);
        chk("g1_hs_score", if4.HS_SCORE, 3);
        chk("g1_hs", if4.HS, 1);
        chk("g1_busy", if4.BUSY, 0);
        steps(3);
        chk("g1_win_sticky", if4.WIN, 1);

        // Game 2: wrong press in round 2
        start4();
        chk("g2_hs_score_kept", if4.HS_SCORE, 3);
        add4(1, 1);
        show4(1);
        press(0, 1);
        add4(0, 2);
        show4(1);
        show4(0);
        press(0, 1);
        chk("g2_mid_lose", if4.LOSE, 0);
        press(0, 1);
        chk("g2_lose", if4.LOSE, 1);
        chk("g2_win", if4.WIN, 0);
        chk("g2_hs_score", if4.HS_SCORE, 3);
        chk("g2_hs", if4.HS, 0);
        chk("g2_level", if4.LEVEL, 2);
        chk("g2_busy", if4.BUSY, 0);

        // Game 3: no press in round 1 -> timeout after 16 WAIT_IN cycles
        start4();
        add4(1, 1);
        show4(1);
        steps(15);
        chk("to_c16_busy", if4.BUSY, 1);
        chk("to_c16_lose", if4.LOSE, 0);
        step();
        chk("to_lose", if4.LOSE, 1);
        chk("to_busy", if4.BUSY, 0);
        chk("to_hs_score", if4.HS_SCORE, 3);

        // Game 4: press on expiry cycle accepted; accepted press restarts the timeout
        start4();
        add4(1, 1);
        show4(1);
        steps(15);
        press(0, 1);
        chk("exp_press_busy", if4.BUSY, 1);
        chk("exp_press_lose", if4.LOSE, 0);
        chk("exp_press_level", if4.LEVEL, 1);
        add4(2, 2);
        show4(1);
        show4(2);
        steps(10);
        press(0, 1);
        steps(15);
        chk("restart_c16_busy", if4.BUSY, 1);
        chk("restart_c16_lose", if4.LOSE, 0);
        step();
        chk("restart_lose", if4.LOSE, 1);
        chk("restart_hs_score", if4.HS_SCORE, 3);

        // 3-button core: RAND=3 folds to 0, mid-show START ignored, RST mid-WAIT_IN
        if3.START_GAME = 1'b1;
        step();
        chk("n3_start_busy", if3.BUSY, 1);
        if3.START_GAME = 1'b0;
        if3.RAND = 2'd3;
        step();
        chk("n3_mod_out", if3.OUT, 0);
        chk("n3_ena", if3.OUT_ENA, 1);
        chk("n3_level", if3.LEVEL, 1);
        if3.START_GAME = 1'b1;
        steps(2);
        chk("n3_midshow_ena", if3.OUT_ENA, 1);
        chk("n3_midshow_level", if3.LEVEL, 1);
        if3.START_GAME = 1'b0;
        steps(3);
        chk("n3_on6_ena", if3.OUT_ENA, 1);
        step();
        chk("n3_off_ena", if3.OUT_ENA, 0);
        chk("n3_off_out", if3.OUT, 0);
        steps(2);
        chk("n3_wait_busy", if3.BUSY, 1);
        press(1, 0);
        if3.RAND = 2'd2;
        step();
        chk("n3_r2_level", if3.LEVEL, 2);
        chk("n3_r2_out0", if3.OUT, 0);
        steps(8);
        chk("n3_r2_out1", if3.OUT, 2);
        chk("n3_r2_ena1", if3.OUT_ENA, 1);
        steps(8);
        press(1, 2);
        chk("n3_lose", if3.LOSE, 1);
        chk("n3_hs_score", if3.HS_SCORE, 1);
        chk("n3_hs", if3.HS, 1);
        if3.START_GAME = 1'b1;
        step();
        chk("n3_g2_hs", if3.HS, 0);
        chk("n3_g2_hs_score", if3.HS_SCORE, 1);
        if3.START_GAME = 1'b0;
        if3.RAND = 2'd1;
        step();
        steps(8);
        steps(3);
        chk("n3_prerst_busy", if3.BUSY, 1);
        chk("n3_prerst_out", if3.OUT, 1);
        rst3 = 1'b1;
        step();
        chk("n3_rst_busy", if3.BUSY, 0);
        chk("n3_rst_hs_score", if3.HS_SCORE, 0);
        chk("n3_rst_level", if3.LEVEL, 0);
        chk("n3_rst_out", if3.OUT, 0);
        chk("n3_rst_ena", if3.OUT_ENA, 0);
        chk("n3_rst_lose", if3.LOSE, 0);
        rst3 = 1'b0;
        step();
        chk("n3_idle_busy", if3.BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
Name: simon_engine

Overview:
Parametrised Simon game core, successor to the fixed 4-lamp controller/timer pair. It covers button count, sequence depth, show/gap/input-timeout durations and high-score tracking. It appends one random button per round, plays the sequence back on a lamp index, then checks player inputs against it. It sits between io_sync/rng and the lamp decode / win-lose-HS outputs of the top level.

Parameters:
NUM_BUTTONS, 4, number of buttons/lamps; must be at least 2.
DEPTH, 16, sequence length needed to win; must be at least 1.
TICK_DIV, 500000, CLK cycles per timing tick; must be at least 1.
ON_TICKS, 250, ticks each lamp is lit during playback; must be at least 1.
OFF_TICKS, 100, ticks of dark gap after each lamp; must be at least 1.
TIMEOUT_TICKS, 2000, ticks allowed per player press before loss; must be at least 1.

Ports:
CLK  in  1  single clock
RST  in  1  synchronous, active-high reset
START_GAME  in  1  already synchronised level; rising edge starts a game
IN  in  BW  button index, BW = $clog2(NUM_BUTTONS)
IN_VALID  in  1  one-cycle strobe qualifying IN
RAND  in  BW  random button index from rng
OUT  out  BW  lamp index during playback
OUT_ENA  out  1  lamp lit
LEVEL  out  LW  current sequence length, LW = $clog2(DEPTH+1)
HS_SCORE  out  LW  best score since reset
WIN  out  1  game won (sticky until next start)
LOSE  out  1  game lost (sticky until next start)
HS  out  1  last game set a new high score (sticky until next start)
BUSY  out  1  high in every state except IDLE and DONE

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset: state IDLE. OUT, OUT_ENA, LEVEL, HS_SCORE, WIN, LOSE, HS and BUSY are all 0. Sequence memory contents are don't-care. HS_SCORE is cleared only by RST.
- START edge: START_GAME is registered one cycle. A rising edge seen in IDLE or DONE does the following next cycle: LEVEL<=0, idx<=0, clear WIN/LOSE/HS, go to ADD. Rising edges in any other state are ignored.
- ADD (1 cycle): mem[LEVEL] <= RAND mod NUM_BUTTONS. If NUM_BUTTONS is a power of 2, this is RAND unchanged. LEVEL<=LEVEL+1, idx<=0, go to SHOW_ON.
- SHOW_ON: OUT=mem[idx], OUT_ENA=1 for exactly ON_TICKS*TICK_DIV cycles, then go to SHOW_OFF.
- SHOW_OFF: OUT_ENA=0 and OUT holds its value, for exactly OFF_TICKS*TICK_DIV cycles.
  - If idx==LEVEL-1: idx<=0, go to WAIT_IN.
  - Otherwise: idx++, go to SHOW_ON.
- WAIT_IN: OUT_ENA=0. IN_VALID is evaluated on the same cycle it is asserted; the result is visible one cycle later. Priority order:
  - IN != mem[idx]: go to DONE with LOSE.
  - IN == mem[idx] and idx<LEVEL-1: idx++, restart the timeout.
  - IN == mem[idx], idx==LEVEL-1 and LEVEL==DEPTH: go to DONE with WIN.
  - Otherwise: go to ADD.
  - No valid press within TIMEOUT_TICKS*TICK_DIV cycles of WAIT_IN entry or the last accepted press: go to DONE with LOSE.
  - An IN_VALID arriving on the expiry cycle takes priority over the timeout.
- IN_VALID is ignored outside WAIT_IN.
- DONE entry: score = LEVEL on a win, LEVEL-1 on a loss. If score > HS_SCORE: HS_SCORE<=score and HS<=1. Equal scores do not set HS. WIN/LOSE/HS hold in DONE until the next START edge or RST.
- Phase timer: the prescaler and tick counter restart on every state entry and on each accepted press. Durations are therefore exact, not quantised to a free-running tick.
- RST mid-operation takes effect at the next edge from any state, including mid-show and mid-timeout.
- Widths: idx and LEVEL are LW bits wide and never exceed DEPTH. The memory is DEPTH x BW registers.

Decomposition:
- Package simon_pkg holds:
  - state_t enum: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, DONE.
  - Width helper functions for BW and LW.
- Sub-module simon_phase_timer holds the prescaler plus duration counter, with inputs RESTART and LOAD_TICKS and output DONE pulse. The TICK_DIV prescaler lives inside it.

Test Plan:
All scenarios use NUM_BUTTONS=4, DEPTH=3, TICK_DIV=2, ON_TICKS=3, OFF_TICKS=1, TIMEOUT_TICKS=8 unless stated otherwise.
1. Reset -> all outputs 0; a START edge with RST held high has no effect.
2. START edge, RAND=2 -> ADD, LEVEL=1; OUT=2 with OUT_ENA=1 for exactly 6 cycles, then dark for 2 cycles; then BUSY=1 in WAIT_IN.
3. Perfect game with RAND 2,0,3 and correct presses each round -> WIN=1, LOSE=0, LEVEL=3, HS_SCORE=3, HS=1, BUSY=0.
4. Second game: wrong press (IN=1 vs 0) in round 2 -> LOSE=1 one cycle after the strobe; HS_SCORE stays 3; HS=0.
5. Timeout: no press in round 1 -> LOSE asserted after 16 WAIT_IN cycles. In a separate run, a correct press on cycle 16 is accepted and the game continues.
6. NUM_BUTTONS=3 with RAND=3 -> OUT=0 on playback. START edge mid-SHOW_ON is ignored. RST mid-WAIT_IN returns to IDLE with HS_SCORE=0.
